// File: rtl/geom_decomp_pkg.sv
// Shared types and helpers for the geometry decompressor pipeline.
// Saturation behaviour is selected with the GEOM_DECOMP_SAT_EN macro.
package geom_decomp_pkg;

  typedef enum logic [1:0] {
    PRED_ZERO   = 2'd0,
    PRED_PREV   = 2'd1,
    PRED_LINEAR = 2'd2,
    PRED_HALF   = 2'd3
  } pred_mode_e;

  // Wide enough for COORD_W+2 intermediates up to a 64-bit coordinate.
  localparam int unsigned WIDE_W = 66;
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t sat_clamp(input wide_t v, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/geom_decompressor_pipe_if.sv
// Residual-in / point-out streaming bundle for geom_decompressor_pipe.
// master = upstream/downstream environment, slave = the decompressor.
interface geom_decompressor_pipe_if #(
  parameter int COORD_W = 32,
  parameter int RES_W   = 16,
  parameter int CNT_W   = 16
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_sof;
  logic [1:0]                in_mode;
  logic signed [RES_W-1:0]   in_res_x;
  logic signed [RES_W-1:0]   in_res_y;
  logic signed [RES_W-1:0]   in_res_z;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sof;
  logic signed [COORD_W-1:0] out_x;
  logic signed [COORD_W-1:0] out_y;
  logic signed [COORD_W-1:0] out_z;
  logic [CNT_W-1:0]          out_idx;
  logic                      ovf_flag;

  modport master (
    output in_valid, in_sof, in_mode, in_res_x, in_res_y, in_res_z, out_ready,
    input  in_ready, out_valid, out_sof, out_x, out_y, out_z, out_idx, ovf_flag
  );

  modport slave (
    input  in_valid, in_sof, in_mode, in_res_x, in_res_y, in_res_z, out_ready,
    output in_ready, out_valid, out_sof, out_x, out_y, out_z, out_idx, ovf_flag
  );
endinterface

// File: rtl/geom_axis_predictor.sv
// One axis: predict from two-point history, add sign-extended residual.
// GEOM_DECOMP_SAT_EN selects clamping with overflow detect; otherwise wraps.
module geom_axis_predictor
  import geom_decomp_pkg::*;
#(
  parameter int COORD_W = 32,
  parameter int RES_W   = 16
) (
  input  pred_mode_e                mode_i,
  input  logic                      sof_i,
  input  logic signed [COORD_W-1:0] p1_i,
  input  logic signed [COORD_W-1:0] p2_i,
  input  logic signed [RES_W-1:0]   res_i,
  output logic signed [COORD_W-1:0] result_o,
  output logic                      ovf_o
);
  localparam int IW = COORD_W + 2;

  logic signed [IW-1:0] p1;
  logic signed [IW-1:0] p2;
  logic signed [IW-1:0] pred;
  logic signed [IW-1:0] sum;

  always_comb begin
    p1   = sof_i ? '0 : IW'(p1_i);
    p2   = sof_i ? '0 : IW'(p2_i);
    pred = '0;
    unique case (mode_i)
      PRED_ZERO:   pred = '0;
      PRED_PREV:   pred = p1;
      PRED_LINEAR: pred = (p1 <<< 1) - p2;
      PRED_HALF:   pred = p1 + ((p1 - p2) >>> 1);
      default:     pred = '0;
    endcase
    sum = pred + IW'(res_i);
  end

`ifdef GEOM_DECOMP_SAT_EN
  wide_t sum_w;
  wide_t clamped;
  assign sum_w    = wide_t'(sum);
  assign clamped  = sat_clamp(sum_w, COORD_W);
  assign ovf_o    = (clamped != sum_w);
  assign result_o = COORD_W'(clamped);
`else
  assign result_o = COORD_W'(sum);
  assign ovf_o    = 1'b0;
`endif

endmodule

// File: rtl/geom_decompressor_pipe.sv
// Streaming XYZ point reconstruction: 1-cycle latency, 1 point/clock.
// GEOM_DECOMP_SAT_EN enables clamping and the sticky overflow flag.
module geom_decompressor_pipe
  import geom_decomp_pkg::*;
#(
  parameter int COORD_W = 32,
  parameter int RES_W   = 16,
  parameter int CNT_W   = 16
) (
  input logic                     clock,
  input logic                     reset,
  geom_decompressor_pipe_if.slave bus
);
  typedef struct packed {
    logic signed [COORD_W-1:0] x;
    logic signed [COORD_W-1:0] y;
    logic signed [COORD_W-1:0] z;
  } coord_t;

  coord_t           p1_q, p2_q, out_q, res_d;
  logic [CNT_W-1:0] cnt_q, out_idx_q, idx_d;
  logic             out_valid_q, out_sof_q, ovf_q;
  logic             ovf_x, ovf_y, ovf_z;
  logic             accept;
  pred_mode_e       mode;

  assign mode     = pred_mode_e'(bus.in_mode);
  assign accept   = bus.in_valid && bus.in_ready;
  assign idx_d    = bus.in_sof ? '0 : cnt_q;

  geom_axis_predictor #(.COORD_W(COORD_W), .RES_W(RES_W)) u_ax_x (
    .mode_i(mode), .sof_i(bus.in_sof), .p1_i(p1_q.x), .p2_i(p2_q.x),
    .res_i(bus.in_res_x), .result_o(res_d.x), .ovf_o(ovf_x)
  );
  geom_axis_predictor #(.COORD_W(COORD_W), .RES_W(RES_W)) u_ax_y (
    .mode_i(mode), .sof_i(bus.in_sof), .p1_i(p1_q.y), .p2_i(p2_q.y),
    .res_i(bus.in_res_y), .result_o(res_d.y), .ovf_o(ovf_y)
  );
  geom_axis_predictor #(.COORD_W(COORD_W), .RES_W(RES_W)) u_ax_z (
    .mode_i(mode), .sof_i(bus.in_sof), .p1_i(p1_q.z), .p2_i(p2_q.z),
    .res_i(bus.in_res_z), .result_o(res_d.z), .ovf_o(ovf_z)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      p1_q        <= '0;
      p2_q        <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (accept) begin
      p2_q        <= p1_q;
      p1_q        <= res_d;
      out_q       <= res_d;
      out_sof_q   <= bus.in_sof;
      out_idx_q   <= idx_d;
      cnt_q       <= idx_d + CNT_W'(1);
      out_valid_q <= 1'b1;
      // sof clears the sticky flag before this point's own overflow is merged
      ovf_q       <= (ovf_q && !bus.in_sof) || ovf_x || ovf_y || ovf_z;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_x     = out_q.x;
  assign bus.out_y     = out_q.y;
  assign bus.out_z     = out_q.z;
  assign bus.out_idx   = out_idx_q;
  assign bus.ovf_flag  = ovf_q;

endmodule
